pe_conv_pipe: RTL and testbench
===============================

Name: pe_conv_pipe

Overview:
- Parametrised mixed-width conversion PE and the successor to the fixed (i16, i32) -> i16 conversion PE.
- Joins two valid/ready operands and extends both to MID_W, signed or unsigned per config.
- Applies add, sub or pass, then narrows to OUT_W by truncation or, optionally, saturation.
- Result passes through a LATENCY-deep bubble-collapsing pipeline; the block sits inside PE tiles feeding the switch fabric.

Parameters:
- IN0_W, 16, operand 0 width (IN0_W <= MID_W)
- IN1_W, 32, operand 1 width (IN1_W <= MID_W)
- MID_W, 32, internal arithmetic width
- OUT_W, 16, result width (OUT_W <= MID_W)
- LATENCY, 1, pipeline register stages, 1..4

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in0_valid  in  1  operand 0 valid
- in0_ready  out  1  operand 0 ready
- in0_data  in  IN0_W  operand 0
- in1_valid  in  1  operand 1 valid
- in1_ready  out  1  operand 1 ready
- in1_data  in  IN1_W  operand 1
- out_valid  out  1  result valid
- out_ready  in  1  result ready
- out_data  out  OUT_W  result
- cfg_signed  in  1  1 = sign-extend operands, 0 = zero-extend (static while busy)
- cfg_op  in  2  0 add, 1 sub (in0-in1), 2 pass in0, 3 reserved
- cfg_sat  in  1  1 = saturate on narrowing; ignored unless PE_CONV_SAT_EN
- sat_hit  out  1  one-cycle pulse when an output transfer carries a clamped value
- error_valid  out  1  sticky error flag
- error_code  out  16  first error code

Behaviour:
- Reset (asynchronous, rst=1):
  - All stage valid bits clear; out_valid=0, out_data=0.
  - sat_hit=0, error_valid=0, error_code=0.
  - Reset mid-operation drops every in-flight token; nothing is replayed.
- Join:
  - Fire = in0_valid & in1_valid & s0_accept.
  - in0_ready = in1_valid & s0_accept; in1_ready = in0_valid & s0_accept.
  - Neither operand is consumed alone.
- Compute (combinational, ahead of stage 0):
  - Both operands extend to MID_W (sext if cfg_signed, else zext).
  - Result r = a+b, a-b or a, modulo 2^MID_W.
- Narrowing:
  - Default: out = r[OUT_W-1:0].
  - Saturation behaviour is defined under Optional Feature.
- Pipeline:
  - Stage i holds {valid, data, sat}.
  - Stage i accepts when it is empty or stage i+1 accepts; the last stage accepts when out_ready=1.
  - Bubbles collapse and there is no combinational path from out_ready to in*_ready beyond this chain.
  - Latency is LATENCY cycles from fire to out_valid with no stall.
  - Throughput is 1 token/cycle under continuous out_ready.
- Output:
  - out_valid and out_data hold stable while out_valid=1 and out_ready=0.
  - Order is preserved.
  - sat_hit pulses in the cycle of out_valid & out_ready when the token's sat bit is set.
- Reserved op (cfg_op=3):
  - The token is still consumed and emitted with data 0.
  - error_valid is set with error_code=16'h0001, only if error_valid was 0.
  - Error state is sticky until rst.
- Simultaneous events:
  - A full pipeline with out_ready=1 accepts a new token in the same cycle one leaves.
  - When the pipeline is empty and out_ready=0, stage 0 still accepts; the pipeline fills to LATENCY tokens, then in*_ready=0.

Optional Feature:
- Macro: PE_CONV_SAT_EN.
- Defined, cfg_sat=1:
  - cfg_signed=1: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - cfg_signed=0: r is clamped to [0, 2^OUT_W-1], with negative results (sub borrow) clamped to 0.
  - The sat bit is set whenever the value was clamped.
- Defined, cfg_sat=0: plain truncation.
- Not defined: cfg_sat is ignored, plain truncation always, sat_hit tied to 0, no clamp logic synthesised.

Test Plan:
- Reset release with no input -> out_valid=0, error_valid=0; cfg_signed=1, add, in0=3, in1=5 -> out_data=8 after LATENCY cycles.
- Signed add with in0=16'hFFFF, in1=1 -> 0. Unsigned add with in0=16'h8000, in1=0 -> 16'h8000. Sub with in0=3, in1=5, signed -> 16'hFFFE.
- Truncation, cfg_sat=0, in0=16'h7FFF, in1=32'h0001_0000 -> 16'h7FFF; with PE_CONV_SAT_EN and cfg_sat=1, signed -> 16'h7FFF with sat_hit=1 on transfer.
- Saturation (PE_CONV_SAT_EN): unsigned sub in0=2, in1=5 -> 0 with sat_hit=1; signed add in0=16'h8000, in1=32'hFFFF_0000 -> 16'h8000 with sat_hit=1.
- Backpressure, LATENCY=3: stream 10 tokens i+i with out_ready toggling 1,0,0,1 -> 10 outputs in order, values stable while stalled, in*_ready=0 once 3 tokens held.
- cfg_op=3 then cfg_op=0 with 1+1 -> first output 0, error_valid=1, error_code=16'h0001 (sticky), second output 2; rst asserted with tokens in flight -> out_valid=0 immediately, flag cleared.

Source files
------------

// File: rtl/pe_conv_pipe.sv
// Purpose: mixed-width conversion PE: joins two operands, extends to MID_W, add/sub/pass, narrows to OUT_W.
// Latency: LATENCY cycles from operand join to out_valid; 1 token/cycle under continuous out_ready.
// Backpressure: bubble-collapsing stage chain; in*_ready falls only when every stage is full and out_ready=0.
//
// Ports: clk/rst (async active-high); in0_*/in1_* operand valid/ready/data; out_* result
// valid/ready/data; cfg_signed/cfg_op/cfg_sat (static while busy); sat_hit pulse on clamped
// output transfer; error_valid/error_code sticky first error (reserved op -> 16'h0001).
// Optional clamp-on-narrow logic is compiled in only when PE_CONV_SAT_EN is defined.
module pe_conv_pipe #(
  parameter int IN0_W   = 16,
  parameter int IN1_W   = 32,
  parameter int MID_W   = 32,
  parameter int OUT_W   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [IN0_W-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [IN1_W-1:0] in1_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_signed,
  input  logic [1:0]       cfg_op,
  input  logic             cfg_sat,
  output logic             sat_hit,
  output logic             error_valid,
  output logic [15:0]      error_code
);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_PASS = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  logic [MID_W-1:0] a_ext;
  logic [MID_W-1:0] b_ext;
  logic [MID_W-1:0] r;
  logic [OUT_W-1:0] res_dat;
  logic             res_sat;
  logic             fire;
  logic             chain;

  logic [LATENCY-1:0] s_vld;
  logic [LATENCY-1:0] s_sat;
  logic [LATENCY-1:0] s_acc;
  logic [OUT_W-1:0]   s_dat [LATENCY];

  // What each stage would load: stage 0 takes the freshly joined result,
  // later stages take their predecessor.
  logic [LATENCY-1:0] ld_vld;
  logic [LATENCY-1:0] ld_sat;
  logic [OUT_W-1:0]   ld_dat [LATENCY];

  // Operand extension
  always_comb begin
    if (cfg_signed) begin
      a_ext = MID_W'($signed(in0_data));
      b_ext = MID_W'($signed(in1_data));
    end else begin
      a_ext = MID_W'(in0_data);
      b_ext = MID_W'(in1_data);
    end
  end

  // Arithmetic, modulo 2^MID_W; reserved op yields 0
  always_comb begin
    case (cfg_op)
      OP_ADD:  r = a_ext + b_ext;
      OP_SUB:  r = a_ext - b_ext;
      OP_PASS: r = a_ext;
      default: r = '0;
    endcase
  end

`ifdef PE_CONV_SAT_EN
  localparam logic [MID_W-1:0] SMAX = MID_W'({(OUT_W-1){1'b1}});
  localparam logic [MID_W-1:0] SMIN = ~SMAX;
  localparam logic [MID_W-1:0] UMAX = MID_W'({OUT_W{1'b1}});

  always_comb begin
    res_dat = r[OUT_W-1:0];
    res_sat = 1'b0;
    if (cfg_sat && cfg_op != OP_RSVD) begin
      if (cfg_signed) begin
        if ($signed(r) > $signed(SMAX)) begin
          res_dat = SMAX[OUT_W-1:0];
          res_sat = 1'b1;
        end else if ($signed(r) < $signed(SMIN)) begin
          res_dat = SMIN[OUT_W-1:0];
          res_sat = 1'b1;
        end
      end else begin
        // Unsigned borrow means the true result is negative: floor at 0.
        if (cfg_op == OP_SUB && a_ext < b_ext) begin
          res_dat = '0;
          res_sat = 1'b1;
        end else if (r > UMAX) begin
          res_dat = UMAX[OUT_W-1:0];
          res_sat = 1'b1;
        end
      end
    end
  end

  assign sat_hit = s_vld[LATENCY-1] & out_ready & s_sat[LATENCY-1];
`else
  assign res_dat = r[OUT_W-1:0];
  assign res_sat = 1'b0;
  assign sat_hit = 1'b0;

  logic unused_sat_path;
  assign unused_sat_path = ^{cfg_sat, s_sat, r};
`endif

  // Stage i accepts if it or any later stage is empty, or the sink is ready.
  // Built as a running OR from the output end so no signal feeds back on itself.
  always_comb begin
    chain = out_ready;
    s_acc = '0;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      chain    = chain | ~s_vld[i];
      s_acc[i] = chain;
    end
  end

  assign fire      = in0_valid & in1_valid & s_acc[0];
  assign in0_ready = in1_valid & s_acc[0];
  assign in1_ready = in0_valid & s_acc[0];

  assign ld_vld[0] = fire;
  assign ld_sat[0] = res_sat;
  assign ld_dat[0] = res_dat;
  for (genvar g = 1; g < LATENCY; g++) begin : g_link
    assign ld_vld[g] = s_vld[g-1];
    assign ld_sat[g] = s_sat[g-1];
    assign ld_dat[g] = s_dat[g-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld <= '0;
      s_sat <= '0;
      for (int i = 0; i < LATENCY; i++) s_dat[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        if (s_acc[i]) begin
          s_vld[i] <= ld_vld[i];
          if (ld_vld[i]) begin
            s_dat[i] <= ld_dat[i];
            s_sat[i] <= ld_sat[i];
          end
        end
      end
    end
  end

  // First error wins; the flag stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_valid <= 1'b0;
      error_code  <= 16'h0000;
    end else if (fire && cfg_op == OP_RSVD && !error_valid) begin
      error_valid <= 1'b1;
      error_code  <= 16'h0001;
    end
  end

  assign out_valid = s_vld[LATENCY-1];
  assign out_data  = s_dat[LATENCY-1];

endmodule

// File: tb/tb_pe_conv_pipe.sv
module tb_pe_conv_pipe;

  localparam int LAT = 3;
`ifdef PE_CONV_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_ready;
  logic [15:0] in0_data;
  logic        in1_valid, in1_ready;
  logic [31:0] in1_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        cfg_signed, cfg_sat;
  logic [1:0]  cfg_op;
  logic        sat_hit, error_valid;
  logic [15:0] error_code;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_conv_pipe #(.IN0_W(16), .IN1_W(32), .MID_W(32), .OUT_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_signed(cfg_signed), .cfg_op(cfg_op), .cfg_sat(cfg_sat),
    .sat_hit(sat_hit), .error_valid(error_valid), .error_code(error_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer result, wrapped to 32 bits, then narrowed by the rules.
  function automatic logic [16:0] model(input bit sgn, input logic [1:0] op, input bit sat,
                                        input logic [15:0] x0, input logic [31:0] x1);
    longint a, b, e, rw, rs;
    logic [15:0] d;
    bit hit;
    longint two31 = 64'd2147483648;
    longint two32 = 64'd4294967296;
    a = sgn ? longint'($signed(x0)) : longint'(x0);
    b = sgn ? longint'($signed(x1)) : longint'(x1);
    case (op)
      2'd0:    e = a + b;
      2'd1:    e = a - b;
      2'd2:    e = a;
      default: e = 0;
    endcase
    rw  = e & 64'hFFFF_FFFF;
    rs  = (rw >= two31) ? rw - two32 : rw;
    d   = rw[15:0];
    hit = 1'b0;
    if (SAT_EN && sat && op != 2'd3) begin
      if (sgn) begin
        if (rs > 32767)       begin d = 16'h7FFF; hit = 1'b1; end
        else if (rs < -32768) begin d = 16'h8000; hit = 1'b1; end
      end else begin
        if (e < 0)            begin d = 16'h0000; hit = 1'b1; end
        else if (rw > 65535)  begin d = 16'hFFFF; hit = 1'b1; end
      end
    end
    return {hit, d};
  endfunction

  task automatic send(input bit sgn, input logic [1:0] op, input bit sat,
                      input logic [15:0] a, input logic [31:0] b);
    int n;
    cfg_signed = sgn; cfg_op = op; cfg_sat = sat;
    in0_data = a; in1_data = b;
    in0_valid = 1'b1; in1_valid = 1'b1;
    #1;
    n = 0;
    while (!(in0_ready && in1_ready) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL send_timeout actual=not_ready required=ready");
    end
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  // Called right after send(): the fire edge is already one cycle behind us.
  task automatic recv(output logic [15:0] d, output bit h, output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    d = out_data;
    h = sat_hit;
    tick();
  endtask

  typedef struct {
    string       name;
    bit          sgn;
    logic [1:0]  op;
    bit          sat;
    logic [15:0] a;
    logic [31:0] b;
    logic [15:0] d_trunc;
    logic [15:0] d_sat;
    bit          hit;
  } vec_t;

  vec_t tab[12];

  initial begin
    logic [15:0] d;
    bit          h;
    int          cyc;
    logic [15:0] q[$];
    logic [16:0] mq[$];
    logic [16:0] m;
    logic [15:0] exp_d;
    logic [15:0] prev_dat;
    bit          prev_stall, fire, xfer;
    int          k, guard, full_seen, outs;
    bit          pat[4];
    bit          rs_sgn, rs_sat;
    logic [1:0]  rs_op;

    tab[0]  = '{"add_s_wrap",    1, 2'd0, 0, 16'hFFFF, 32'h0000_0001, 16'h0000, 16'h0000, 0};
    tab[1]  = '{"add_u",         0, 2'd0, 0, 16'h8000, 32'h0000_0000, 16'h8000, 16'h8000, 0};
    tab[2]  = '{"sub_s",         1, 2'd1, 0, 16'h0003, 32'h0000_0005, 16'hFFFE, 16'hFFFE, 0};
    tab[3]  = '{"trunc",         1, 2'd0, 0, 16'h7FFF, 32'h0001_0000, 16'h7FFF, 16'h7FFF, 0};
    tab[4]  = '{"sat_s_hi",      1, 2'd0, 1, 16'h7FFF, 32'h0001_0000, 16'h7FFF, 16'h7FFF, 1};
    tab[5]  = '{"sat_u_borrow",  0, 2'd1, 1, 16'h0002, 32'h0000_0005, 16'hFFFD, 16'h0000, 1};
    tab[6]  = '{"sat_s_lo",      1, 2'd0, 1, 16'h8000, 32'hFFFF_0000, 16'h8000, 16'h8000, 1};
    tab[7]  = '{"pass_u",        0, 2'd2, 0, 16'h1234, 32'h0000_DEAD, 16'h1234, 16'h1234, 0};
    tab[8]  = '{"sub_u_wrap",    0, 2'd1, 0, 16'h0000, 32'h0000_0001, 16'hFFFF, 16'hFFFF, 0};
    tab[9]  = '{"sat_u_hi",      0, 2'd0, 1, 16'hFFFF, 32'h0000_0001, 16'h0000, 16'hFFFF, 1};
    tab[10] = '{"sat_s_inrange", 1, 2'd1, 1, 16'hFFFB, 32'h0000_0003, 16'hFFF8, 16'hFFF8, 0};
    tab[11] = '{"pass_s_sat",    1, 2'd2, 1, 16'h8000, 32'h0000_0000, 16'h8000, 16'h8000, 0};

    // Reset
    rst = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
    out_ready = 1'b1; cfg_signed = 1'b1; cfg_op = 2'd0; cfg_sat = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sat_hit", 32'(sat_hit), 32'd0);
    check("rst_err_code", 32'(error_code), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_err_valid", 32'(error_valid), 32'd0);
    check("idle_in0_ready", 32'(in0_ready), 32'd0);

    // First token and latency
    send(1'b1, 2'd0, 1'b0, 16'd3, 32'd5);
    recv(d, h, cyc);
    check("first_data", 32'(d), 32'd8);
    check("first_latency", 32'(cyc), 32'(LAT));

    // Table
    for (int i = 0; i < 12; i++) begin
      send(tab[i].sgn, tab[i].op, tab[i].sat, tab[i].a, tab[i].b);
      recv(d, h, cyc);
      exp_d = SAT_EN ? tab[i].d_sat : tab[i].d_trunc;
      check({tab[i].name, "_data"}, 32'(d), 32'(exp_d));
      check({tab[i].name, "_sat_hit"}, 32'(h), 32'(SAT_EN & tab[i].hit));
      check({tab[i].name, "_latency"}, 32'(cyc), 32'(LAT));
    end

    // Backpressure: 10 tokens i+i, out_ready pattern 1,0,0,1
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    cfg_signed = 1'b1; cfg_op = 2'd0; cfg_sat = 1'b0;
    k = 0; guard = 0; full_seen = 0; outs = 0; prev_stall = 1'b0; prev_dat = '0;
    while ((k < 10 || q.size() > 0) && guard < 300) begin
      out_ready = pat[guard % 4];
      in0_valid = (k < 10); in1_valid = (k < 10);
      in0_data = 16'(k); in1_data = 32'(k);
      #1;
      if (q.size() == LAT && !out_ready) begin
        full_seen++;
        check("bp_full_ready", {30'd0, in0_ready, in1_ready}, 32'd0);
      end
      if (prev_stall) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'(prev_dat));
      end
      fire = in0_valid & in0_ready & in1_valid & in1_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        outs++;
        if (q.size() == 0) check("bp_spurious_out", 32'(out_data), 32'hFFFF_FFFF);
        else check("bp_order", 32'(out_data), 32'(q.pop_front()));
      end
      prev_stall = out_valid & ~out_ready;
      prev_dat = out_data;
      if (fire) begin
        q.push_back(16'(2 * k));
        k++;
      end
      tick();
      guard++;
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    check("bp_outputs", 32'(outs), 32'd10);
    check("bp_full_seen", 32'(full_seen > 0), 32'd1);

    // Randomized batches against the model; cfg changes only with the pipe empty
    for (int bt = 0; bt < 8; bt++) begin
      rs_sgn = 1'($urandom_range(0, 1));
      rs_op  = 2'($urandom_range(0, 2));
      rs_sat = 1'($urandom_range(0, 1));
      cfg_signed = rs_sgn; cfg_op = rs_op; cfg_sat = rs_sat;
      k = 0; guard = 0;
      while ((k < 25 || mq.size() > 0) && guard < 600) begin
        in0_valid = (k < 25) && ($urandom_range(0, 3) != 0);
        in1_valid = (k < 25) && ($urandom_range(0, 3) != 0);
        in0_data = 16'($urandom);
        in1_data = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($signed(16'($urandom)));
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (in0_ready) check("rnd_join0", 32'(in1_valid), 32'd1);
        if (in1_ready) check("rnd_join1", 32'(in0_valid), 32'd1);
        fire = in0_valid & in0_ready & in1_valid & in1_ready;
        if (out_valid && out_ready) begin
          if (mq.size() == 0) check("rnd_spurious_out", 32'(out_data), 32'hFFFF_FFFF);
          else begin
            m = mq.pop_front();
            check("rnd_data", 32'(out_data), 32'(m[15:0]));
            check("rnd_sat_hit", 32'(sat_hit), 32'(m[16]));
          end
        end
        if (fire) begin
          mq.push_back(model(rs_sgn, rs_op, rs_sat, in0_data, in1_data));
          k++;
        end
        tick();
        guard++;
      end
      check("rnd_batch_done", 32'(k == 25 && mq.size() == 0), 32'd1);
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;

    // Reserved op, sticky error
    check("pre_err_valid", 32'(error_valid), 32'd0);
    send(1'b1, 2'd3, 1'b0, 16'd7, 32'd9);
    recv(d, h, cyc);
    check("rsvd_data", 32'(d), 32'd0);
    check("rsvd_sat_hit", 32'(h), 32'd0);
    check("rsvd_err_valid", 32'(error_valid), 32'd1);
    check("rsvd_err_code", 32'(error_code), 32'h0001);
    send(1'b1, 2'd0, 1'b0, 16'd1, 32'd1);
    recv(d, h, cyc);
    check("after_rsvd_data", 32'(d), 32'd2);
    check("sticky_err_valid", 32'(error_valid), 32'd1);
    check("sticky_err_code", 32'(error_code), 32'h0001);

    // Reset with tokens in flight
    out_ready = 1'b0;
    cfg_signed = 1'b1; cfg_op = 2'd0; cfg_sat = 1'b0;
    in0_data = 16'd4; in1_data = 32'd4; in0_valid = 1'b1; in1_valid = 1'b1;
    tick(); tick(); tick(); tick();
    check("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_err_valid", 32'(error_valid), 32'd0);
    check("arst_err_code", 32'(error_code), 32'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_replay_valid", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
